mem_responder: RTL

Word-addressed memory responder that serves the datapath's MAR/MDR memory port using a request/ready handshake and a configurable wait-state latency. It replaces the zero-latency RAM so the future control unit must stall on `mem_ready`. It sits between the datapath's `Read`/`Write`/MAR/MDR signals and a 2^ADDR_W × 32 storage array.

---
 rtl/mem_responder_pkg.sv | 16 +
 rtl/mem_array_sp.sv | 39 +++
 rtl/mem_responder.sv | 97 +++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the wait-state memory responder: FSM encoding,
// default latency and counter width.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT        = 2'd1,
        ST_ACCESS_DONE = 2'd2,
        ST_RELEASE     = 2'd3
    } state_e;

    localparam int WAIT_STATES_DEFAULT = 2;
    localparam int CNT_W               = 4;
    localparam int DATA_W              = 32;

endpackage

// File: rtl/mem_array_sp.sv
// Single-port synchronous word array with write-enable and a registered read
// port; only the read register is cleared, never the storage.
module mem_array_sp
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: storage has no reset so it maps onto plain RAM; contents survive clear.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// MAR/MDR memory responder: accepts a read or write request, waits WAIT_STATES
// cycles, performs the access and pulses mem_ready for one cycle.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_STATES = WAIT_STATES_DEFAULT,
    parameter int ADDR_W      = 8
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              read_enable,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] RAM_data_in,
    output logic [DATA_W-1:0] RAM_data_out,
    output logic              mem_ready,
    output logic              busy
);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                is_read_q;
    logic                mem_ready_q;
    logic                busy_q;
    logic                access;
    logic                any_req;

    assign any_req = read_enable | write_enable;
    assign access  = (state_q == ST_WAIT) && (cnt_q == '0);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            is_read_q   <= 1'b0;
            mem_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        addr_q    <= address;
                        data_q    <= RAM_data_in;
                        is_read_q <= read_enable;  // read wins a simultaneous request
                        cnt_q     <= CNT_W'(WAIT_STATES);
                        busy_q    <= 1'b1;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        mem_ready_q <= 1'b1;
                        state_q     <= ST_ACCESS_DONE;
                    end
                end
                ST_ACCESS_DONE: begin
                    mem_ready_q <= 1'b0;
                    if (any_req) begin
                        state_q <= ST_RELEASE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RELEASE: begin
                    if (!any_req) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mem_array_sp #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clock),
        .rst_ni  (clear),
        .we_i    (access & ~is_read_q),
        .re_i    (access & is_read_q),
        .addr_i  (addr_q),
        .wdata_i (data_q),
        .rdata_o (RAM_data_out)
    );

    assign mem_ready = mem_ready_q;
    assign busy      = busy_q;

endmodule
